// File: rtl/trail_writer.sv
// Frame-buffer write feeder: sweeps the buffer to background after reset/restart,
// then writes one two-pixel trail word per live bike on each frame tick.
module trail_writer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter logic [3:0]  BG_COLOR   = 4'h0,
    parameter logic [3:0]  RED_COLOR  = 4'h5,
    parameter logic [3:0]  BLUE_COLOR = 4'h3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        game_restart,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    input  logic        red_alive,
    input  logic        blue_alive,
    output logic        WE,
    output logic [18:0] write_address,
    output logic [15:0] Data_In,
    output logic        busy,
    output logic        clear_done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {CLEAR, IDLE, WR_RED, WR_BLUE} state_t;

    localparam logic [18:0] HALF       = 19'(H_RES / 2);
    localparam logic [18:0] WORDS      = 19'((H_RES / 2) * V_RES);
    localparam logic [10:0] X_LIM      = 11'(H_RES);
    localparam logic [10:0] Y_LIM      = 11'(V_RES);
    localparam logic [15:0] BG_WORD    = {4'h0, BG_COLOR, 4'h0, BG_COLOR};
    localparam logic [15:0] RED_WORD   = {4'h0, RED_COLOR, 4'h0, RED_COLOR};
    localparam logic [15:0] BLUE_WORD  = {4'h0, BLUE_COLOR, 4'h0, BLUE_COLOR};

    state_t      state;
    logic [18:0] cnt;
    logic        f_d;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic        b_alive;
    logic        tick;

    // Odd x lands in the word holding its even/odd pair.
    function automatic logic [18:0] addr_of(input logic [9:0] x, input logic [9:0] y);
        return {9'd0, y} * HALF + {10'd0, x[9:1]};
    endfunction

    function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    endfunction

    assign tick      = frame_clk & ~f_d;
    assign state_dbg = state;

    // Outputs are registered alongside the state they describe; cnt is the next
    // sweep address, and CLEAR lingers one cycle at cnt==WORDS to retire cleanly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= CLEAR;
            cnt           <= '0;
            f_d           <= 1'b0;
            b_x           <= '0;
            b_y           <= '0;
            b_alive       <= 1'b0;
            WE            <= 1'b0;
            write_address <= '0;
            Data_In       <= '0;
            busy          <= 1'b1;
            clear_done    <= 1'b0;
        end else begin
            f_d <= frame_clk;
            if (game_restart) begin
                state         <= CLEAR;
                cnt           <= 19'd1;
                WE            <= 1'b1;
                write_address <= '0;
                Data_In       <= BG_WORD;
                busy          <= 1'b1;
                clear_done    <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        if (cnt == WORDS) begin
                            state      <= IDLE;
                            WE         <= 1'b0;
                            busy       <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            WE            <= 1'b1;
                            write_address <= cnt;
                            Data_In       <= BG_WORD;
                            cnt           <= cnt + 19'd1;
                        end
                    end
                    IDLE: begin
                        WE <= 1'b0;
                        if (tick) begin
                            b_x           <= blue_x;
                            b_y           <= blue_y;
                            b_alive       <= blue_alive;
                            state         <= WR_RED;
                            busy          <= 1'b1;
                            WE            <= red_alive && on_screen(red_x, red_y);
                            write_address <= addr_of(red_x, red_y);
                            Data_In       <= RED_WORD;
                        end
                    end
                    WR_RED: begin
                        state         <= WR_BLUE;
                        WE            <= b_alive && on_screen(b_x, b_y);
                        write_address <= addr_of(b_x, b_y);
                        Data_In       <= BLUE_WORD;
                    end
                    WR_BLUE: begin
                        state <= IDLE;
                        WE    <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= CLEAR;
                        cnt   <= '0;
                        WE    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/trail_writer.md
Name: trail_writer

Overview:
- Upstream feeder of the frame buffer write port. Owns Data_In, write_address and WE into the frameRAM behind the pixel-colour stage.
- After reset or game restart, sweeps the whole buffer to background colour.
- On each frame tick, writes one trail word for each live bike at its current position.
- Buffer word packs two pixels: nibble [3:0] is the even X pixel, nibble [11:8] is the odd X pixel. Trails are 2 px wide and aligned to even X, so each write is a full word and needs no read-modify-write.

Parameters:
- H_RES, 640, visible width in pixels; must be even.
- V_RES, 480, visible height in pixels.
- BG_COLOR, 4'h0, colour enum for background.
- RED_COLOR, 4'h5, colour enum for red trail.
- BLUE_COLOR, 4'h3, colour enum for blue trail.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  frame strobe (~60 Hz level); its rising edge is the frame tick.
- game_restart  in  1  synchronous request to re-clear the buffer.
- red_x, red_y  in  10 each  red bike pixel position.
- blue_x, blue_y  in  10 each  blue bike pixel position.
- red_alive, blue_alive  in  1 each  bike still in play.
- WE  out  1  frame buffer write enable.
- write_address  out  19  word address.
- Data_In  out  16  word to write.
- busy  out  1  state != IDLE.
- clear_done  out  1  buffer fully cleared since the last reset or restart.

Behaviour:
- Derived constant: WORDS = (H_RES/2)*V_RES = 153600.
- Address = y*(H_RES/2) + x/2, computed 19 bits wide with no truncation. Maximum is 153599.
- Word format: {4'h0, c, 4'h0, c}, where c is the colour enum.
- States: CLEAR, IDLE, WR_RED, WR_BLUE. Reset value is CLEAR with cnt=0.
- Reset values of outputs (while Reset is high): WE=0, write_address=0, Data_In=0, clear_done=0, busy=1.
- Outputs decode from registered state, cnt and latched position registers only. There is no combinational path from any input to any output.
- CLEAR: each cycle WE=1, write_address=cnt, Data_In={4'h0,BG,4'h0,BG}; cnt increments. When cnt==WORDS-1, the next state is IDLE and clear_done is set to 1. Total is exactly WORDS write cycles.
- Tick detection: f_d registers frame_clk each cycle; tick = frame_clk & ~f_d.
- IDLE: WE=0. On tick, latch red_x, red_y, blue_x, blue_y, red_alive and blue_alive, then go to WR_RED.
- WR_RED, one cycle:
  - WE=1 only if latched red_alive=1, x<H_RES and y<V_RES.
  - write_address = address of the latched red position.
  - Data_In = word with RED_COLOR.
  - Next state is WR_BLUE.
- WR_BLUE: same as WR_RED using blue values and BLUE_COLOR. Next state is IDLE.
- Latency: the tick edge latches inputs; the red write is in the following cycle and the blue write in the cycle after. busy is high for exactly 2 cycles per tick.
- Odd x is written to the even/odd pair containing it (x/2). Both nibbles of the word take the trail colour.
- Tick in CLEAR, WR_RED or WR_BLUE is dropped, not queued.
- game_restart sampled high in any state: next state is CLEAR with cnt=0 and clear_done=0. This takes priority over a simultaneous tick and aborts any in-progress write sequence. The current cycle's output is still issued.
- Reset asserted mid-operation immediately forces the reset values. After Reset deasserts, the full clear sweep restarts from address 0.
- Both bikes at the same position: blue is written last and wins.

Test Plan:
- Reset, then release -> exactly 153600 consecutive WE=1 cycles, addresses 0..153599, Data_In=16'h0000. clear_done rises the cycle after address 153599; busy falls at the same time.
- Idle, red at (100,50), blue at (200,60), both alive, frame_clk rises -> red write at address 16050 with data 16'h0505, then blue write at 19300 with data 16'h0303, then WE=0.
- red_x=101, red_y=0 -> address 50, data 16'h0505. red_x=639, red_y=479 -> address 153599.
- red_alive=0 and blue_y=480 -> both write cycles have WE=0, and busy is still high for 2 cycles.
- frame_clk held high for 1000 cycles -> exactly one write pair. Tick during CLEAR -> no trail write after the clear completes.
- game_restart asserted in the WR_RED cycle -> red write issued, no blue write, a new sweep starts at address 0 and clear_done drops. Reset pulse at cnt=5000 -> outputs go to 0 at once, and the sweep restarts at address 0 after release.
